// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a shared external 32-bit shifter.
// Rotates take a second shifter pass in the opposite direction, and the two results are ORed.
module shift_arbiter #(
  parameter logic RR_RESET_PRI = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [31:0] req0_amt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [31:0] req1_amt,
  input  logic [1:0]  req1_op,
  output logic [31:0] sh_d,
  output logic [31:0] sh_s,
  output logic        sh_lnr,
  input  logic [31:0] sh_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data
);

  typedef enum logic [1:0] {IDLE, SHIFT1, SHIFT2, RESP} state_t;

  state_t      state_q, state_d;
  logic        pri_q, pri_d;
  logic        id_q, id_d;
  logic [31:0] data_q, data_d;
  logic [31:0] amt_q, amt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] acc_q, acc_d;

  logic        gnt0, gnt1;
  logic        isRot;
  logic [5:0]  rotInv;

  assign gnt0   = req0_valid & (~req1_valid | ~pri_q);
  assign gnt1   = req1_valid & (~req0_valid |  pri_q);
  assign isRot  = op_q[1];
  assign rotInv = 6'd32 - {1'b0, amt_q[4:0]};

  always_comb begin
    state_d    = state_q;
    pri_d      = pri_q;
    id_d       = id_q;
    data_d     = data_q;
    amt_d      = amt_q;
    op_d       = op_q;
    acc_d      = acc_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sh_d       = 32'd0;
    sh_s       = 32'd0;
    sh_lnr     = 1'b0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_data   = 32'd0;
    case (state_q)
      IDLE: begin
        req0_ready = gnt0 & ~RST;
        req1_ready = gnt1 & ~RST;
        if (req0_ready) begin
          id_d    = 1'b0;
          data_d  = req0_data;
          amt_d   = req0_amt;
          op_d    = req0_op;
          pri_d   = 1'b1;
          state_d = SHIFT1;
        end else if (req1_ready) begin
          id_d    = 1'b1;
          data_d  = req1_data;
          amt_d   = req1_amt;
          op_d    = req1_op;
          pri_d   = 1'b0;
          state_d = SHIFT1;
        end
      end
      SHIFT1: begin
        sh_d    = data_q;
        sh_s    = isRot ? {27'd0, amt_q[4:0]} : amt_q;
        sh_lnr  = ~op_q[0];
        acc_d   = sh_y;
        state_d = (isRot && (amt_q[4:0] != 5'd0)) ? SHIFT2 : RESP;
      end
      SHIFT2: begin
        // Second pass brings the bits that fell off the end back around.
        sh_d    = data_q;
        sh_s    = {26'd0, rotInv};
        sh_lnr  = op_q[0];
        acc_d   = acc_q | sh_y;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = acc_q;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pri_q   <= RR_RESET_PRI;
      id_q    <= 1'b0;
      data_q  <= 32'd0;
      amt_q   <= 32'd0;
      op_q    <= 2'd0;
      acc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      id_q    <= id_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table, arbitration, stall and reset
// sequences, then random commands scored against a bit-by-bit shift/rotate reference model.
module tb_shift_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data = '0, req0_amt = '0, req1_data = '0, req1_amt = '0;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [31:0] sh_d, sh_s, sh_y;
  logic        sh_lnr;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;

  int nChecks = 0;
  int nFail   = 0;

  shift_arbiter #(.RR_RESET_PRI(1'b0)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .sh_d(sh_d), .sh_s(sh_s), .sh_lnr(sh_lnr), .sh_y(sh_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  // Stand-in for the external SHIFT32: logical shift, amounts above 31 give zero.
  assign sh_y = sh_lnr ? (sh_d << sh_s) : (sh_d >> sh_s);

  always #5 CLK = ~CLK;

  typedef struct {
    bit          id;
    logic [31:0] data;
    logic [31:0] amt;
    logic [1:0]  op;
    logic [31:0] expData;
    int          expLat;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] refResult(input logic [31:0] d, input logic [31:0] a,
                                            input logic [1:0] op);
    logic [31:0] r = d;
    int n;
    if (op[1]) begin
      n = int'(a % 32);
      for (int i = 0; i < n; i++)
        r = op[0] ? {r[0], r[31:1]} : {r[30:0], r[31]};
    end else begin
      n = (a > 32) ? 32 : int'(a);
      for (int i = 0; i < n; i++)
        r = op[0] ? {1'b0, r[31:1]} : {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic int refLatency(input logic [31:0] a, input logic [1:0] op);
    return (op[1] && (a % 32 != 0)) ? 3 : 2;
  endfunction

  task automatic setReq(input bit id, input logic v, input logic [31:0] d,
                        input logic [31:0] a, input logic [1:0] op);
    if (id == 1'b0) begin
      req0_valid = v; req0_data = d; req0_amt = a; req0_op = op;
    end else begin
      req1_valid = v; req1_data = d; req1_amt = a; req1_op = op;
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Issue one command, measure accept-to-response latency, optionally stall the consumer.
  task automatic applyStimulus(input bit id, input logic [31:0] d, input logic [31:0] a,
                               input logic [1:0] op, input logic [31:0] expData,
                               input int expLat, input int hold);
    int waited = 0;
    int lat = 0;
    bit seen = 0;
    bit stable = 1;
    logic [31:0] holdData;
    logic holdId;
    @(negedge CLK);
    setReq(id, 1'b1, d, a, op);
    #1;
    while (!(id ? req1_ready : req0_ready) && waited < 20) begin
      @(negedge CLK); #1; waited++;
    end
    if (waited >= 20) begin
      checkOutput("ready_timeout", 32'(waited), 32'd0);
      setReq(id, 1'b0, d, a, op);
      return;
    end
    @(posedge CLK); #1;
    setReq(id, 1'b0, d, a, op);
    for (int n = 1; n <= 8; n++) begin
      @(negedge CLK);
      lat = n;
      if (n == 1) begin
        checkOutput("shift1_sh_d", sh_d, d);
        checkOutput("shift1_sh_s", sh_s, op[1] ? {27'd0, a[4:0]} : a);
        checkOutput("shift1_sh_lnr", {31'd0, sh_lnr}, {31'd0, ~op[0]});
        checkOutput("busy_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    checkOutput("latency", 32'(seen ? lat : 99), 32'(expLat));
    checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, id});
    checkOutput("rsp_data", rsp_data, expData);
    if (hold > 0) begin
      holdData = rsp_data;
      holdId = rsp_id;
      setReq(~id, 1'b1, 32'h1, 32'h1, 2'b00);
      for (int h = 0; h < hold; h++) begin
        @(negedge CLK);
        if (!rsp_valid || rsp_data !== holdData || rsp_id !== holdId ||
            req0_ready || req1_ready) stable = 0;
      end
      setReq(~id, 1'b0, 32'h1, 32'h1, 2'b00);
      checkOutput("stall_stable", {31'd0, stable}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int grants[$];
    bit bothReady;
    bit sawRsp;
    bit rid;
    logic [31:0] rd, ra;
    logic [1:0] rop;

    vecs[0] = '{1'b0, 32'h000000F0, 32'd4,  2'b00, 32'h00000F00, 2};
    vecs[1] = '{1'b1, 32'h00000001, 32'd1,  2'b11, 32'h80000000, 3};
    vecs[2] = '{1'b0, 32'h80000001, 32'd4,  2'b10, 32'h00000018, 3};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'd40, 2'b01, 32'h00000000, 2};
    vecs[4] = '{1'b0, 32'h12345678, 32'd32, 2'b10, 32'h12345678, 2};
    vecs[5] = '{1'b1, 32'h80000000, 32'd31, 2'b01, 32'h00000001, 2};
    vecs[6] = '{1'b0, 32'hABCD1234, 32'd36, 2'b11, 32'h4ABCD123, 3};
    vecs[7] = '{1'b1, 32'h00000001, 32'd32, 2'b00, 32'h00000000, 2};

    // Reset state, with both requesters asserting valid during reset.
    RST = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_sh", sh_d | sh_s | {31'd0, sh_lnr}, 32'd0);
    @(negedge CLK);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    RST = 1'b0;

    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].id, vecs[i].data, vecs[i].amt, vecs[i].op,
                    vecs[i].expData, vecs[i].expLat, 0);

    // Consumer stall: response and readies must hold while rsp_ready is low.
    applyStimulus(1'b0, 32'h0000BEEF, 32'd8, 2'b10, 32'h00BEEF00, 3, 5);

    // Arbitration from reset with both requesters continuously valid.
    doReset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 32'h1; req0_amt = 32'd1; req0_op = 2'b00;
    req1_valid = 1'b1; req1_data = 32'h2; req1_amt = 32'd1; req1_op = 2'b01;
    bothReady = 0;
    for (int c = 0; c < 60 && grants.size() < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) bothReady = 1;
      if (req0_ready) grants.push_back(0);
      else if (req1_ready) grants.push_back(1);
      @(negedge CLK);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checkOutput("both_ready", {31'd0, bothReady}, 32'd0);
    checkOutput("grant_count", 32'(grants.size()), 32'd4);
    for (int g = 0; g < grants.size(); g++)
      checkOutput($sformatf("grant_%0d", g), 32'(grants[g]), 32'(g % 2));
    repeat (4) @(negedge CLK);
    rsp_ready = 1'b0;

    // Reset during SHIFT2 drops the command and restores the reset priority.
    doReset();
    @(negedge CLK);
    setReq(1'b0, 1'b1, 32'h00000001, 32'd1, 2'b11);
    #1;
    checkOutput("rst_test_ready0", {31'd0, req0_ready}, 32'd1);
    @(posedge CLK); #1;
    setReq(1'b0, 1'b0, 32'h00000001, 32'd1, 2'b11);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("shift2_sh_s", sh_s, 32'd31);
    checkOutput("shift2_sh_lnr", {31'd0, sh_lnr}, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    checkOutput("rst_outputs", sh_d | sh_s | rsp_data |
                {29'd0, sh_lnr, rsp_valid, rsp_id}, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checkOutput("rst_ready_held", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("rst_priority", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    sawRsp = 0;
    repeat (8) begin
      @(negedge CLK);
      if (rsp_valid) sawRsp = 1;
    end
    rsp_ready = 1'b0;
    checkOutput("dropped_no_rsp", {31'd0, sawRsp}, 32'd0);

    // Random commands against the reference model.
    for (int k = 0; k < 40; k++) begin
      rid = 1'($urandom_range(0, 1));
      rop = 2'($urandom_range(0, 3));
      rd  = $urandom;
      ra  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
      applyStimulus(rid, rd, ra, rop, refResult(rd, ra, rop), refLatency(ra, rop),
                    ($urandom_range(0, 4) == 0) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter RR_RESET_PRI, default 0: the requester that holds priority after reset.
REQ-002 CLK  input  1  sole clock; all state changes on posedge CLK.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents a shift command.
REQ-005 reqN_ready  output  1  command from requester N is accepted in this cycle.
REQ-006 reqN_data  input  32  operand for requester N.
REQ-007 reqN_amt  input  32  shift amount for requester N.
REQ-008 reqN_op  input  2  operation code: 00 SLL, 01 SRL, 10 ROL, 11 ROR.
REQ-009 sh_d  output  32  operand to the shared external 32-bit shifter (SHIFT32).
REQ-010 sh_s  output  32  amount to the shared shifter.
REQ-011 sh_lnr  output  1  direction to the shared shifter: 1 = left, 0 = right.
REQ-012 sh_y  input  32  combinational result from the shared shifter.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer accepts the result.
REQ-015 rsp_id  output  1  requester index that owns the result.
REQ-016 rsp_data  output  32  result value.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT1, SHIFT2 and RESP.
REQ-018 In IDLE, grant: only one valid requester -> that requester; both valid -> the requester holding priority.
REQ-019 reqN_ready SHALL be 1 only in IDLE and only for the granted requester; it is combinational from the valid inputs and the priority pointer.
REQ-020 Accept (valid&ready) SHALL latch data, amt, op and id, then move to SHIFT1.
REQ-021 On accept, the priority pointer SHALL move to the requester that was not served.
REQ-022 SHIFT1 SHALL drive the shifter from the latched operand.
  - SLL/SRL: sh_s = amt unchanged; sh_lnr = 1 for SLL, 0 for SRL.
  - ROL/ROR: sh_s = {27'b0, amt[4:0]}; sh_lnr = 1 for ROL, 0 for ROR.
REQ-023 SHIFT1 SHALL register sh_y into the accumulator.
  - Rotate with amt[4:0] != 0 -> SHIFT2.
  - Any other command -> RESP.
REQ-024 SHIFT2 SHALL drive the latched operand, sh_s = 32 - amt[4:0] (6-bit value, zero-extended) and the opposite direction; it SHALL OR sh_y into the accumulator, then move to RESP.
REQ-025 SLL/SRL with amt > 31 SHALL return 0; a rotate uses amt modulo 32, so amt[4:0] = 0 returns the operand unchanged.
REQ-026 In RESP: rsp_valid = 1, rsp_data = accumulator, rsp_id = latched id.
REQ-027 rsp_data and rsp_id SHALL stay stable until rsp_ready = 1; on that cycle the FSM returns to IDLE.
REQ-028 Latency from accept to rsp_valid SHALL be:
  - 2 cycles for SLL, SRL, and rotate with amt[4:0] = 0;
  - 3 cycles for rotate with amt[4:0] != 0.
REQ-029 Commands arriving while busy SHALL NOT be accepted; requesters hold valid until they see ready.
REQ-030 In IDLE and RESP, sh_d, sh_s and sh_lnr SHALL be driven to 0.
REQ-031 Throughput SHALL be one command per (latency + 1) cycles at most; there is no pipelining and no overlap.

Reset
REQ-032 RST = 1 at a clock edge SHALL force all of the following, regardless of state:
  - state IDLE; priority = RR_RESET_PRI;
  - accumulator and latched command = 0;
  - rsp_valid, rsp_id, rsp_data, sh_d, sh_s, sh_lnr = 0.
REQ-033 A command in flight when reset hits SHALL be dropped with no response.
REQ-034 Both reqN_ready SHALL be 0 while RST = 1.

Verification
REQ-035 req0 SLL, data 0x000000F0, amt 4 -> rsp 0x00000F00, id 0, rsp_valid 2 cycles after accept.
REQ-036 req1 ROR, data 0x00000001, amt 1 -> rsp 0x80000000, id 1 after 3 cycles; ROL 0x80000001 by 4 -> 0x00000018.
REQ-037 Boundary amounts:
  - SRL 0xFFFFFFFF by 40 -> 0x00000000.
  - ROL 0x12345678 by 32 -> 0x12345678 after 2 cycles, with no SHIFT2 cycle.
REQ-038 Arbitration:
  - Both requesters valid continuously from reset (RR_RESET_PRI = 0) -> grants alternate 0,1,0,1.
  - Never are both ready signals 1 in the same cycle.
REQ-039 rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data and rsp_id stay stable, and both ready signals stay 0.
REQ-040 RST pulsed during SHIFT2 -> on the next cycle all outputs are 0 and the FSM is in IDLE; no response ever appears for the dropped command.
